// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage buffer and the stages that feed it.
// Holds the default payload width, the legal buffer depth range, the field
// widths used to pack a pipeline payload into in_data, and the encoding of
// the per-cycle buffer operation.
package pipe_pkg;

  // Default payload width and legal depth range (depth must be a power of two).
  localparam int PIPE_DATA_W    = 32;
  localparam int PIPE_DEPTH_MIN = 2;
  localparam int PIPE_DEPTH_MAX = 16;

  // Field widths used by upstream stages when packing in_data.
  localparam int PC_W       = 32;
  localparam int REG_ADDR_W = 4;
  localparam int EXEC_CMD_W = 4;
  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W    = 24;

  // Per-cycle buffer operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_e;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle between an upstream stage, the buffer and the
// downstream stage.
//   in_valid/in_ready/in_data    : upstream -> buffer
//   out_valid/out_ready/out_data : buffer -> downstream
// master : the environment around the buffer (drives in_*, out_ready)
// slave  : the buffer itself (drives in_ready, out_valid, out_data)
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage_mem.sv
// Storage array for the pipeline-stage buffer: DEPTH x DATA_W, one
// synchronous write port and one asynchronous read port. Contents are never
// observed while invalid, so the array has no reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module pipe_stage_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic FIFO buffer between two pipeline stages.
// A push needs in_valid && in_ready, a pop needs out_valid && out_ready.
// Data becomes visible one cycle after it is pushed (no bypass). flush empties
// the buffer and wins over freeze; freeze holds all state and blocks both
// handshakes.
//   clk    : clock
//   rst    : asynchronous active-low reset
//   flush  : discard all entries (and any push this cycle)
//   freeze : hold state, deassert in_ready/out_valid
//   bus    : handshake bundle (slave side)
//   count  : number of occupied entries
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int DEPTH  = PIPE_DEPTH_MIN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   freeze,
  pipe_stage_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              not_empty_s;
  logic              not_full_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] rdata_s;

  assign not_empty_s = (count_q != CNT_W'(0));
  assign not_full_s  = (count_q < CNT_W'(DEPTH));

  // in_ready is also gated by rst so it reads 0 while reset is held; it never
  // depends on out_ready, so a full buffer does not accept on a same-cycle pop.
  assign in_ready_s  = rst & ~freeze & ~flush & not_full_s;
  assign out_valid_s = ~freeze & ~flush & not_empty_s;

  assign push_s = bus.in_valid & in_ready_s;
  assign pop_s  = out_valid_s & bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = not_empty_s ? rdata_s : {DATA_W{1'b0}};
  assign count         = count_q;

  pipe_stage_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Next-state for pointers and occupancy. Freeze needs no branch of its own:
  // it already suppresses push_s and pop_s, so everything holds.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so +1 wraps DEPTH-1 -> 0.
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case (buf_op_e'({push_s, pop_s}))
        OP_PUSH: count_d = count_q + CNT_W'(1);
        OP_POP:  count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload width in bits.
REQ-002 Parameter DEPTH, default 2, SHALL set the buffer entries; legal values are powers of two, 2 to 16.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port flush  input  1  SHALL discard all buffered entries.
REQ-006 Port freeze  input  1  SHALL hold all state and block both handshakes.
REQ-007 Port in_valid  input  1  SHALL indicate that the upstream stage presents in_data.
REQ-008 Port in_ready  output  1  SHALL indicate that the buffer accepts in_data this cycle.
REQ-009 Port in_data  input  DATA_W  SHALL carry the upstream payload (PC, control bits, operands).
REQ-010 Port out_valid  output  1  SHALL indicate that out_data holds the oldest entry.
REQ-011 Port out_ready  input  1  SHALL indicate that the downstream stage consumes out_data.
REQ-012 Port out_data  output  DATA_W  SHALL carry the oldest buffered payload.
REQ-013 Port count  output  $clog2(DEPTH)+1  SHALL give the current number of occupied entries.

Function
REQ-014 A push SHALL occur on a cycle with in_valid && in_ready.
REQ-015 A pop SHALL occur on a cycle with out_valid && out_ready.
REQ-016 in_ready SHALL equal !freeze && !flush && (count < DEPTH), with no combinational path from out_ready.
REQ-017 out_valid SHALL equal !freeze && !flush && (count != 0).
REQ-018 out_data SHALL equal the entry at the read pointer when count != 0, and all-zeros when count == 0.
REQ-019 Ordering SHALL be FIFO, with latency exactly one cycle from push to out_valid; there is no same-cycle bypass.
REQ-020 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-021 The read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-022 When count == DEPTH, in_ready SHALL be 0 and a held in_valid SHALL neither be lost nor duplicated.
REQ-023 When count == 0, out_ready SHALL have no effect on state.
REQ-024 With flush=1 at a clock edge, count and both pointers SHALL become 0 on that edge and any push that cycle SHALL be discarded.
REQ-025 Flush SHALL take priority over freeze.
REQ-026 With freeze=1 and flush=0, the pointers, count and storage SHALL be unchanged on that edge.
REQ-027 Storage contents SHALL never be read while invalid, so storage needs no reset.

Reset
REQ-028 While rst=0, the pointers and count SHALL be 0, and in_ready, out_valid and out_data SHALL be 0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL drop all entries immediately; after release, the first push SHALL appear at out_data one cycle later.
REQ-030 The first clock edge after rst rises SHALL be able to accept a push.

Structure
REQ-031 Shared package pipe_pkg SHALL hold the DATA_W default and the DEPTH limits (MIN 2, MAX 16).
REQ-032 Shared package pipe_pkg SHALL hold the pipeline field-width constants (PC 32, REG_ADDR 4, EXEC_CMD 4, SHIFT_OP 12, IMM24 24) used to pack in_data.
REQ-033 Storage SHALL be one sub-module, pipe_stage_mem: DEPTH x DATA_W, one write port, asynchronous read.
REQ-034 Pointer, count and handshake logic SHALL remain in pipe_stage_buf.

Verification
REQ-035 Scenario, DEPTH=2: push 0xA1, 0xA2 with out_ready=0 -> count=2, in_ready=0; then out_ready=1 -> out_data 0xA1 then 0xA2, then out_valid=0 and out_data=0.
REQ-036 Scenario, continuous stream: in_valid=1 and out_ready=1 for 20 cycles with data 1..20 -> all 20 values appear in order, count stays at 1 after the first push, and no value is lost or duplicated.
REQ-037 Scenario, wrap-around at DEPTH=4: push 10 values with random pops -> pointers wrap, and the output order matches the input order.
REQ-038 Scenario, flush: count=2 plus a simultaneous push, flush pulsed 1 cycle -> next cycle count=0, out_valid=0, and the pushed value is never output.
REQ-039 Scenario, freeze: freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count unchanged; after release, output resumes with the same oldest entry.
REQ-040 Scenario, reset mid-operation: rst=0 asserted between clock edges with count=2 -> count=0 and out_valid=0 immediately; after release, a push of 0x55 gives out_data=0x55 one cycle later.
